// File: rtl/icetap_capture.sv
// Capture controller for the icetap logic analyzer: fills a circular sample
// buffer, detects a masked trigger, stores the post-trigger window, then stops.
module icetap_capture #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] trigger_mask,
  input  logic [DATA_WIDTH-1:0] trigger_value,
  input  logic [ADDR_WIDTH-1:0] post_trigger_cnt,
  input  logic                  sample_ena,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  mem_wr_ena,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [1:0]            state,
  output logic                  triggered,
  output logic [ADDR_WIDTH-1:0] trigger_addr,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  wrapped
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRE_TRIG  = 2'd1,
    POST_TRIG = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] pcnt;

  logic                  do_write;
  logic                  trig_hit;
  logic                  wp_wraps;
  logic [ADDR_WIDTH-1:0] wp_next;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    do_write = 1'b0;
    if (!abort && sample_ena && (state_q == PRE_TRIG || state_q == POST_TRIG))
      do_write = 1'b1;
    trig_hit = ((sample_data ^ trigger_value) & trigger_mask) == '0;
    wp_wraps = &wp;
    wp_next  = wp + ADDR_WIDTH'(1);
  end

  assign state = state_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wp           <= '0;
      pcnt         <= '0;
      mem_wr_ena   <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      triggered    <= 1'b0;
      trigger_addr <= '0;
      start_addr   <= '0;
      wrapped      <= 1'b0;
    end else begin
      mem_wr_ena <= do_write;

      // Datapath shared by the pre- and post-trigger phases.
      if (do_write) begin
        mem_wr_addr <= wp;
        mem_wr_data <= sample_data;
        wp          <= wp_next;
        if (wp_wraps)
          wrapped <= 1'b1;
        // Once wrapped, the next slot to be overwritten holds the oldest sample.
        start_addr <= (wrapped || wp_wraps) ? wp_next : '0;
      end

      if (abort) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (start) begin
              state_q      <= PRE_TRIG;
              wp           <= '0;
              wrapped      <= 1'b0;
              triggered    <= 1'b0;
              trigger_addr <= '0;
              start_addr   <= '0;
              pcnt         <= post_trigger_cnt;
            end
          end
          PRE_TRIG: begin
            if (sample_ena && trig_hit) begin
              triggered    <= 1'b1;
              trigger_addr <= wp;
              state_q      <= (pcnt == '0) ? DONE : POST_TRIG;
            end
          end
          POST_TRIG: begin
            if (sample_ena) begin
              pcnt <= pcnt - ADDR_WIDTH'(1);
              if (pcnt == ADDR_WIDTH'(1))
                state_q <= DONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icetap_capture.sv
// Directed self-checking bench for icetap_capture with hand-computed expectations.
module tb_icetap_capture;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [DW-1:0] trigger_mask;
  logic [DW-1:0] trigger_value;
  logic [AW-1:0] post_trigger_cnt;
  logic          sample_ena;
  logic [DW-1:0] sample_data;
  logic          mem_wr_ena;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [1:0]    state;
  logic          triggered;
  logic [AW-1:0] trigger_addr;
  logic [AW-1:0] start_addr;
  logic          wrapped;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_base;

  icetap_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .trigger_mask     (trigger_mask),
    .trigger_value    (trigger_value),
    .post_trigger_cnt (post_trigger_cnt),
    .sample_ena       (sample_ena),
    .sample_data      (sample_data),
    .mem_wr_ena       (mem_wr_ena),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data),
    .state            (state),
    .triggered        (triggered),
    .trigger_addr     (trigger_addr),
    .start_addr       (start_addr),
    .wrapped          (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_wr_ena === 1'b1) wr_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [DW-1:0] mask, input logic [DW-1:0] value,
                     input logic [AW-1:0] post);
    trigger_mask     = mask;
    trigger_value    = value;
    post_trigger_cnt = post;
    start            = 1'b1;
    sample_ena       = 1'b0;
    tick();
    start = 1'b0;
    check("arm_state", state, 1);
  endtask

  task automatic feed(input logic [DW-1:0] d);
    sample_ena  = 1'b1;
    sample_data = d;
    tick();
    sample_ena  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; sample_ena = 1'b0;
    sample_data = '0; trigger_mask = '0; trigger_value = '0; post_trigger_cnt = '0;

    // Reset, then samples with no start
    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_wr_ena", mem_wr_ena, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      feed(DW'(i + 5));
      check("idle_wr_ena", mem_wr_ena, 0);
      check("idle_state", state, 0);
    end
    check("idle_wr_count", wr_count, 0);
    check("idle_outs", {triggered, wrapped, trigger_addr, start_addr, mem_wr_addr, mem_wr_data}, 0);

    // Basic trigger; the sample beside start must not be written
    trigger_mask = 8'hFF; trigger_value = 8'h05; post_trigger_cnt = 8'd3;
    start = 1'b1; sample_ena = 1'b1; sample_data = 8'h77;
    tick();
    start = 1'b0; sample_ena = 1'b0;
    check("basic_start_state", state, 1);
    check("basic_start_nowr", mem_wr_ena, 0);
    wr_base = wr_count;
    for (int i = 0; i <= 10; i++) begin
      feed(DW'(i));
      if (i <= 8) begin
        check("basic_wr_ena", mem_wr_ena, 1);
        check("basic_wr_addr", mem_wr_addr, i);
        check("basic_wr_data", mem_wr_data, i);
      end else begin
        check("basic_done_nowr", mem_wr_ena, 0);
      end
      check("basic_state", state, (i < 5) ? 1 : (i < 8) ? 2 : 3);
    end
    check("basic_trig", triggered, 1);
    check("basic_trig_addr", trigger_addr, 5);
    check("basic_wrapped", wrapped, 0);
    check("basic_start_addr", start_addr, 0);
    check("basic_wr_count", wr_count - wr_base, 9);

    // Wrap: 300 non-matching samples, then trigger and two more
    arm(8'hFF, 8'hAA, 8'd2);
    wr_base = wr_count;
    for (int i = 0; i < 300; i++) feed(DW'(i & 8'h7F));
    check("wrap_pre_state", state, 1);
    check("wrap_pre_wrapped", wrapped, 1);
    feed(8'hAA);
    check("wrap_trig_addr", trigger_addr, 44);
    check("wrap_trig_wr_addr", mem_wr_addr, 44);
    check("wrap_trig_state", state, 2);
    check("wrap_trig_start_addr", start_addr, 45);
    feed(8'h01);
    feed(8'h02);
    check("wrap_last_wr_addr", mem_wr_addr, 46);
    check("wrap_last_wr_data", mem_wr_data, 8'h02);
    check("wrap_state", state, 3);
    check("wrap_wrapped", wrapped, 1);
    check("wrap_start_addr", start_addr, 47);
    feed(8'hAA);
    check("wrap_done_nowr", mem_wr_ena, 0);
    check("wrap_wr_count", wr_count - wr_base, 303);

    // Zero post count, zero mask
    arm(8'h00, 8'h5A, 8'd0);
    check("zero_clr_trig", triggered, 0);
    check("zero_clr_wrapped", wrapped, 0);
    feed(8'h33);
    check("zero_wr_ena", mem_wr_ena, 1);
    check("zero_wr_addr", mem_wr_addr, 0);
    check("zero_wr_data", mem_wr_data, 8'h33);
    check("zero_trig", triggered, 1);
    check("zero_trig_addr", trigger_addr, 0);
    check("zero_state", state, 3);
    feed(8'h34);
    check("zero_done_nowr", mem_wr_ena, 0);

    // Gaps in POST_TRIG, then abort with a live sample
    arm(8'hFF, 8'h10, 8'd4);
    feed(8'h0F);
    feed(8'h10);
    check("gap_trig_state", state, 2);
    check("gap_trig_addr", trigger_addr, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_idle_nowr", mem_wr_ena, 0);
      feed(DW'(8'h20 + i));
      check("gap_wr_addr", mem_wr_addr, 2 + i);
      check("gap_state", state, 2);
    end
    abort = 1'b1; sample_ena = 1'b1; sample_data = 8'h99;
    tick();
    abort = 1'b0; sample_ena = 1'b0;
    check("abort_nowr", mem_wr_ena, 0);
    check("abort_state", state, 0);
    check("abort_trig_addr", trigger_addr, 1);
    check("abort_trig", triggered, 1);

    // start + abort together from DONE
    arm(8'h00, 8'h00, 8'd0);
    feed(8'h44);
    check("sa_done", state, 3);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_state", state, 0);

    // start while in PRE_TRIG is ignored
    arm(8'hFF, 8'hEE, 8'd0);
    feed(8'h01);
    feed(8'h02);
    feed(8'h03);
    start = 1'b1;
    feed(8'h04);
    start = 1'b0;
    check("restart_wr_addr", mem_wr_addr, 3);
    check("restart_state", state, 1);
    feed(8'hEE);
    check("restart_trig_addr", trigger_addr, 4);
    check("restart_done", state, 3);

    // Reset mid-capture kills an in-flight write
    arm(8'hFF, 8'hEE, 8'd5);
    feed(8'h01);
    check("mid_wr_ena_pre", mem_wr_ena, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_wr_ena", mem_wr_ena, 0);
    check("mid_rst_state", state, 0);
    check("mid_rst_outs", {triggered, wrapped, trigger_addr, start_addr, mem_wr_addr, mem_wr_data}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
